// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states, mux selects.
package riscv_pkg;

  localparam int OPCODE_W = 7;
  localparam int STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;

endpackage

// File: rtl/mc_imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational, independent of FSM state.
module mc_imm_src_decoder
  import riscv_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD:   imm_src = IMM_I;
      OP_ITYPE:  imm_src = IMM_I;
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences shared ALU, unified memory port and register file.
// Outputs decode combinationally from the state register; memory states stall on mem_ready.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic [1:0]          imm_src,
  output logic                illegal_instr,
  output logic                instr_retire,
  output logic [STATE_W-1:0]  state
);

  state_e state_q, state_d;

  logic pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic illegal_raw, retire_raw;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      // JAL redirects the PC, then reuses ALUWB to write old PC + 4 into rd.
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    retire_raw    = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    result_src    = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        alu_op       = ALUOP_ADD;
        result_src   = RES_ALU;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_raw = 1'b0;
          default:                                                  illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        result_src    = RES_ALUOUT;
        mem_write_raw = 1'b1;
        retire_raw    = mem_ready;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_RD2;
        alu_op       = ALUOP_SUB;
        result_src   = RES_ALUOUT;
        pc_write_raw = zero;
        retire_raw   = 1'b1;
      end
      S_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        alu_op       = ALUOP_ADD;
        result_src   = RES_ALUOUT;
        pc_write_raw = 1'b1;
      end
      default: begin
        adr_src = 1'b0;
      end
    endcase
  end

  // Strobes are gated by rst_n directly so an abort takes effect in the same cycle.
  assign pc_write      = pc_write_raw  & rst_n;
  assign ir_write      = ir_write_raw  & rst_n;
  assign mem_write     = mem_write_raw & rst_n;
  assign reg_write     = reg_write_raw & rst_n;
  assign illegal_instr = illegal_raw   & rst_n;
  assign instr_retire  = retire_raw    & rst_n;

  assign state = STATE_W'(state_q);

  mc_imm_src_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

endmodule
